// File: rtl/mpc2_arith_pkg.sv
// Shared width constants for the MPC-II arithmetic unit (divider and multiplier).
// Keeping them in one place keeps both blocks width-matched.
package mpc2_arith_pkg;

  localparam int QW    = 28;
  localparam int DW    = 16;
  localparam int PW    = QW + DW;
  localparam int CNT_W = 5;
  localparam int AW    = PW + 1;

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: conditionally add the multiplicand into the upper half,
// then shift the whole accumulator right by one bit.
module mul_step
  import mpc2_arith_pkg::*;
(
  input  logic [AW-1:0] acc,
  input  logic [DW-1:0] dr,
  output logic [AW-1:0] acc_next
);

  logic [DW:0] hi;

  // The upper DW+1 bits never carry out: the top bit is always 0 after each shift.
  always_comb begin
    hi       = acc[AW-1:QW] + (acc[0] ? {1'b0, dr} : '0);
    acc_next = {hi, acc[QW-1:0]} >> 1;
  end

endmodule

// File: rtl/mul_28b_16b_int.sv
// Sequential multiply-accumulate p = q*d + r, one product bit per clock.
// Optional overflow flag enabled by defining MUL_28B_16B_OVF_EN.
module mul_28b_16b_int
  import mpc2_arith_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [QW-1:0] q,
  input  logic [DW-1:0] d,
  input  logic [DW-1:0] r,
  input  logic          startp,
  output logic [PW-1:0] p,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

  logic [CNT_W-1:0] i_q, i_d;
  logic [AW-1:0]    acc_q, acc_d, acc_step;
  logic [DW-1:0]    dr_q, dr_d;
  logic             done_q, done_d;
  logic             last_step;

  mul_step u_step (
    .acc      (acc_q),
    .dr       (dr_q),
    .acc_next (acc_step)
  );

  assign last_step = (i_q == CNT_W'(1));

  // A start pulse always wins, so a restart silently discards any run in flight.
  always_comb begin
    i_d    = i_q;
    acc_d  = acc_q;
    dr_d   = dr_q;
    done_d = 1'b0;
    if (startp) begin
      acc_d = {1'b0, r, q};
      dr_d  = d;
      i_d   = CNT_W'(QW);
    end else if (i_q != '0) begin
      acc_d  = acc_step;
      i_d    = i_q - CNT_W'(1);
      done_d = last_step;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q    <= '0;
      acc_q  <= '0;
      dr_q   <= '0;
      done_q <= 1'b0;
    end else begin
      i_q    <= i_d;
      acc_q  <= acc_d;
      dr_q   <= dr_d;
      done_q <= done_d;
    end
  end

`ifdef MUL_28B_16B_OVF_EN
  logic ovf_q, ovf_d;

  // Flag a result that cannot be a QW-bit dividend; held until the next start.
  always_comb begin
    ovf_d = ovf_q;
    if (startp) begin
      ovf_d = 1'b0;
    end else if (last_step) begin
      ovf_d = |acc_step[PW-1:QW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign p    = acc_q[PW-1:0];
  assign busy = (i_q != '0);
  assign done = done_q;

endmodule

// File: tb/tb_mul_28b_16b_int.sv
// Directed bench for mul_28b_16b_int: latency, boundary vectors, restart, async reset
// and a divide/multiply round trip against a behavioural divider.
module tb_mul_28b_16b_int;

  logic        clk;
  logic        rst;
  logic [27:0] q;
  logic [15:0] d;
  logic [15:0] r;
  logic        startp;
  logic [43:0] p;
  logic        busy;
  logic        done;
  logic        ovf;

  int testsRun;
  int testsFailed;

  mul_28b_16b_int dut (
    .clk    (clk),
    .rst    (rst),
    .q      (q),
    .d      (d),
    .r      (r),
    .startp (startp),
    .p      (p),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Pulse startp for one clock; returns just after the sampling edge.
  task automatic applyStimulus(input logic [27:0] qIn, input logic [15:0] dIn, input logic [15:0] rIn);
    @(posedge clk); #1;
    q      = qIn;
    d      = dIn;
    r      = rIn;
    startp = 1'b1;
    @(posedge clk); #1;
    startp = 1'b0;
  endtask

  // Counts busy cycles after the start edge, bounded so a stuck DUT cannot hang the run.
  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic runOp(input logic [27:0] qIn, input logic [15:0] dIn, input logic [15:0] rIn,
                       output int cycles);
    applyStimulus(qIn, dIn, rIn);
    waitIdle(cycles);
  endtask

  initial begin
    int          cycles;
    logic        sawDone;
    logic [27:0] z;
    logic [15:0] dv;
    logic        expOvf;
    int          rtFails;

    testsRun    = 0;
    testsFailed = 0;
    rst    = 1'b1;
    q      = '0;
    d      = '0;
    r      = '0;
    startp = 1'b0;

    #12;
    checkOutput("rstP", 64'(p), 64'h0);
    checkOutput("rstBusy", 64'(busy), 64'h0);
    checkOutput("rstDone", 64'(done), 64'h0);
    checkOutput("rstOvf", 64'(ovf), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 142*7+6 = 1000
    runOp(28'd142, 16'd7, 16'd6, cycles);
    checkOutput("t1Cycles", 64'(cycles), 64'd28);
    checkOutput("t1Done", 64'(done), 64'h1);
    checkOutput("t1P", 64'(p), 64'd1000);
    checkOutput("t1Ovf", 64'(ovf), 64'h0);
    @(posedge clk); #1;
    checkOutput("t1DoneClr", 64'(done), 64'h0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t1Hold", 64'(p), 64'd1000);
    checkOutput("t1IdleBusy", 64'(busy), 64'h0);

    // Largest operands: (2^28-1)(2^16-1)+(2^16-1) = 0xFFFF0000000
`ifdef MUL_28B_16B_OVF_EN
    expOvf = 1'b1;
`else
    expOvf = 1'b0;
`endif
    runOp(28'hFFFFFFF, 16'hFFFF, 16'hFFFF, cycles);
    checkOutput("t2Cycles", 64'(cycles), 64'd28);
    checkOutput("t2P", 64'(p), 64'hFFFF0000000);
    checkOutput("t2Ovf", 64'(ovf), 64'(expOvf));
    @(posedge clk); #1;
    checkOutput("t2OvfHold", 64'(ovf), 64'(expOvf));

    // q=0: no early exit, result is just r
    applyStimulus(28'd0, 16'h1234, 16'h00AB);
    checkOutput("t3OvfClr", 64'(ovf), 64'h0);
    waitIdle(cycles);
    checkOutput("t3Cycles", 64'(cycles), 64'd28);
    checkOutput("t3P", 64'(p), 64'hAB);

    runOp(28'h5, 16'h0, 16'h0, cycles);
    checkOutput("t4Cycles", 64'(cycles), 64'd28);
    checkOutput("t4P", 64'(p), 64'h0);

    // Restart at cycle 10: the first run must leave no trace
    applyStimulus(28'd142, 16'd7, 16'd6);
    repeat (9) @(posedge clk);
    #1;
    runOp(28'd3, 16'd5, 16'd1, cycles);
    checkOutput("t5Cycles", 64'(cycles), 64'd28);
    checkOutput("t5Done", 64'(done), 64'h1);
    checkOutput("t5P", 64'(p), 64'd16);

    // Async reset between edges, mid-run
    applyStimulus(28'hABCDEF1, 16'h9876, 16'h4321);
    repeat (14) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("t6Busy", 64'(busy), 64'h0);
    checkOutput("t6P", 64'(p), 64'h0);
    checkOutput("t6Done", 64'(done), 64'h0);
    checkOutput("t6Ovf", 64'(ovf), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      sawDone |= done;
    end
    checkOutput("t6NoDone", 64'(sawDone), 64'h0);

    // Round trip through a behavioural divider: (z/d)*d + z%d == z
    rtFails = 0;
    for (int n = 0; n < 1000; n++) begin
      z  = 28'($urandom);
      dv = 16'($urandom_range(1, 16'hFFFF));
      runOp(z / 28'(dv), dv, 16'(z % 28'(dv)), cycles);
      checkOutput($sformatf("rt%0dP", n), 64'(p), 64'(z));
      if (p !== 44'(z)) rtFails++;
    end
    checkOutput("rtOvf", 64'(ovf), 64'h0);
    checkOutput("rtLastCycles", 64'(cycles), 64'd28);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
